// File: rtl/audio_pkg.sv
// Shared constants and types for the audio front end.
//
// NPTS      : points per FFT frame
// SAMPLE_W  : sample width, two's complement
// COEF_W    : Hann coefficient width, unsigned Q0.17
// hann_coef : periodic 16-point Hann window, 0.5*(1-cos(2*pi*i/16))*2^17,
//             rounded to nearest and clipped to 131071 (affects i = 8 only)
// state_t   : frame streamer FSM states
package audio_pkg;

  localparam int NPTS     = 16;
  localparam int SAMPLE_W = 18;
  localparam int COEF_W   = 17;

  localparam logic [COEF_W-1:0] hann_coef [NPTS] = '{
    17'd0,      17'd4989,   17'd19195,  17'd40456,
    17'd65536,  17'd90616,  17'd111877, 17'd126083,
    17'd131071, 17'd126083, 17'd111877, 17'd90616,
    17'd65536,  17'd40456,  17'd19195,  17'd4989
  };

  typedef enum logic {IDLE, STREAM} state_t;

endpackage

// File: rtl/hann_window_mult.sv
// Registered Hann weighting stage: y = sat18((x * w + 2^16) >>> 17).
//
// clk   : clock
// reset : synchronous active-high reset, clears y
// en    : load a new product into y; y holds while low
// x     : signed sample
// w     : unsigned Q0.17 coefficient
// y     : registered, rounded and saturated result
module hann_window_mult
  import audio_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic        [COEF_W-1:0]   w,
  output logic signed [SAMPLE_W-1:0] y
);

  localparam int PROD_W = SAMPLE_W + COEF_W + 1;
  localparam logic signed [PROD_W-1:0] HALF = PROD_W'(1) << (COEF_W - 1);
  localparam logic signed [PROD_W-1:0] SMAX = PROD_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SMIN = -SMAX - PROD_W'(1);

  logic signed [COEF_W:0]   w_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] rounded;
  logic signed [PROD_W-1:0] shifted;

  // Zero-extend the coefficient so the multiply stays fully signed.
  assign w_s     = {1'b0, w};
  assign prod    = x * w_s;
  assign rounded = prod + HALF;
  assign shifted = rounded >>> COEF_W;

  always_ff @(posedge clk) begin
    if (reset) begin
      y <= '0;
    end else if (en) begin
      if (shifted > SMAX)      y <= SMAX[SAMPLE_W-1:0];
      else if (shifted < SMIN) y <= SMIN[SAMPLE_W-1:0];
      else                     y <= shifted[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/fft_frame_streamer.sv
// Snapshots a 16-tap sample window every HOP new samples and streams it
// oldest-first into the FFT input with a valid/ready handshake.
//
// Optional feature macro: HANN_WINDOW_EN. When defined, each sample is
// Hann-weighted through a registered multiplier (two clocks new_t->s_valid);
// otherwise samples pass through unmodified (one clock new_t->s_valid).
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   new_t, t0..t15 : shifter strobe and window (t0 newest, t15 oldest)
//   s_data/s_index/s_valid/s_ready/s_last : frame sample stream
//   overrun        : one-cycle pulse when a frame trigger is dropped
module fft_frame_streamer
  import audio_pkg::*;
#(
  parameter int HOP = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_t,
  input  logic [SAMPLE_W-1:0] t0,
  input  logic [SAMPLE_W-1:0] t1,
  input  logic [SAMPLE_W-1:0] t2,
  input  logic [SAMPLE_W-1:0] t3,
  input  logic [SAMPLE_W-1:0] t4,
  input  logic [SAMPLE_W-1:0] t5,
  input  logic [SAMPLE_W-1:0] t6,
  input  logic [SAMPLE_W-1:0] t7,
  input  logic [SAMPLE_W-1:0] t8,
  input  logic [SAMPLE_W-1:0] t9,
  input  logic [SAMPLE_W-1:0] t10,
  input  logic [SAMPLE_W-1:0] t11,
  input  logic [SAMPLE_W-1:0] t12,
  input  logic [SAMPLE_W-1:0] t13,
  input  logic [SAMPLE_W-1:0] t14,
  input  logic [SAMPLE_W-1:0] t15,
  output logic [SAMPLE_W-1:0] s_data,
  output logic [3:0]          s_index,
  output logic                s_valid,
  input  logic                s_ready,
  output logic                s_last,
  output logic                overrun
);

  localparam logic [4:0] FILL_FULL = 5'd16;
  localparam logic [4:0] HOP_LAST  = 5'(HOP - 1);

  logic [SAMPLE_W-1:0] taps [NPTS];
  assign taps[0]  = t0;   assign taps[1]  = t1;
  assign taps[2]  = t2;   assign taps[3]  = t3;
  assign taps[4]  = t4;   assign taps[5]  = t5;
  assign taps[6]  = t6;   assign taps[7]  = t7;
  assign taps[8]  = t8;   assign taps[9]  = t9;
  assign taps[10] = t10;  assign taps[11] = t11;
  assign taps[12] = t12;  assign taps[13] = t13;
  assign taps[14] = t14;  assign taps[15] = t15;

  // ---------------- fill / hop counters ----------------
  logic [4:0] fill_reg;
  logic [4:0] hop_reg;
  logic       trigger;

  // fill_reg == 15 on a strobe means the count becomes 16 right now.
  assign trigger = new_t && ((fill_reg == 5'd15) ||
                             (fill_reg == FILL_FULL && hop_reg == HOP_LAST));

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_reg <= '0;
      hop_reg  <= '0;
    end else if (new_t) begin
      if (fill_reg != FILL_FULL) fill_reg <= fill_reg + 5'd1;
      if (fill_reg == 5'd15)           hop_reg <= '0;
      else if (fill_reg == FILL_FULL)  hop_reg <= (hop_reg == HOP_LAST) ? 5'd0 : hop_reg + 5'd1;
    end
  end

  // ---------------- frame FSM ----------------
  state_t              state_reg;
  logic [3:0]          idx_reg;
  logic                overrun_reg;
  logic [SAMPLE_W-1:0] f_reg [NPTS];
  logic                busy;     // a frame is still owed to the FFT
  logic                advance;  // element idx_reg is consumed this cycle
  logic                capture;

  assign capture = (state_reg == IDLE) && trigger && !busy;

  // f[0] is the oldest tap, so f[gi] = t(15-gi).
  for (genvar gi = 0; gi < NPTS; gi++) begin : g_frame
    always_ff @(posedge clk) begin
      if (reset)        f_reg[gi] <= '0;
      else if (capture) f_reg[gi] <= taps[NPTS-1-gi];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= trigger && busy;
      if (state_reg == IDLE) begin
        if (capture) begin
          idx_reg   <= '0;
          state_reg <= STREAM;
        end
      end else if (advance) begin
        idx_reg <= idx_reg + 4'd1;
        if (idx_reg == 4'd15) state_reg <= IDLE;
      end
    end
  end

  assign overrun = overrun_reg;

`ifdef HANN_WINDOW_EN
  // Output register stage: the multiplier result plus its index/last tag.
  // It reloads only when empty or being accepted, so a stalled beat holds.
  logic                       out_valid_reg;
  logic                       out_last_reg;
  logic [3:0]                 out_index_reg;
  logic                       load;
  logic signed [SAMPLE_W-1:0] win_data;

  assign load    = !out_valid_reg || s_ready;
  assign advance = (state_reg == STREAM) && load;
  // The frame stays busy until its final beat leaves the output register.
  assign busy    = (state_reg == STREAM) || out_valid_reg;

  hann_window_mult u_hann (
    .clk   (clk),
    .reset (reset),
    .en    (advance),
    .x     ($signed(f_reg[idx_reg])),
    .w     (hann_coef[idx_reg]),
    .y     (win_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_index_reg <= '0;
    end else if (load) begin
      out_valid_reg <= (state_reg == STREAM);
      out_last_reg  <= (idx_reg == 4'd15);
      out_index_reg <= idx_reg;
    end
  end

  assign s_valid = out_valid_reg;
  assign s_index = out_index_reg;
  assign s_last  = out_valid_reg && out_last_reg;
  assign s_data  = win_data;
`else
  assign advance = (state_reg == STREAM) && s_ready;
  assign busy    = (state_reg == STREAM);
  assign s_valid = (state_reg == STREAM);
  assign s_index = idx_reg;
  assign s_last  = (state_reg == STREAM) && (idx_reg == 4'd15);
  assign s_data  = f_reg[idx_reg];
`endif

endmodule

// File: tb/tb_fft_frame_streamer.sv
module tb_fft_frame_streamer;

  localparam int HOP = 8;
`ifdef HANN_WINDOW_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_t = 1'b0;
  logic        s_ready = 1'b0;
  logic [17:0] tap [16];
  logic [17:0] s_data;
  logic [3:0]  s_index;
  logic        s_valid, s_last, overrun;

  always #5 clk = ~clk;

  fft_frame_streamer #(.HOP(HOP)) dut (
    .clk(clk), .reset(reset), .new_t(new_t),
    .t0(tap[0]),   .t1(tap[1]),   .t2(tap[2]),   .t3(tap[3]),
    .t4(tap[4]),   .t5(tap[5]),   .t6(tap[6]),   .t7(tap[7]),
    .t8(tap[8]),   .t9(tap[9]),   .t10(tap[10]), .t11(tap[11]),
    .t12(tap[12]), .t13(tap[13]), .t14(tap[14]), .t15(tap[15]),
    .s_data(s_data), .s_index(s_index), .s_valid(s_valid),
    .s_ready(s_ready), .s_last(s_last), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;
  int rmode = 0;        // 0: ready high, 1: random ready, 2: ready low
  bit run_cmp = 1'b0;

  // Reference model state: the frame owed to the FFT and how far it got.
  int m_n;              // strobes since reset
  int m_frame [16];
  int m_pos, m_wait;
  bit m_active, m_ovr;

  // Observed traffic, written only by the compare process.
  int beat_data [$];
  int beat_index [$];
  int frames = 0;
  int ovr_cnt = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(logic [17:0] v);
    return int'($signed(v));
  endfunction

  function automatic int win(int x, int i);
`ifdef HANN_WINDOW_EN
    real    c;
    longint w, p;
    c = 0.5 * (1.0 - $cos(2.0 * 3.14159265358979 * i / 16.0)) * 131072.0;
    w = longint'($rtoi(c + 0.5));
    if (w > 131071) w = 131071;
    p = (longint'(x) * w + 65536) >>> 17;
    if (p > 131071) p = 131071;
    if (p < -131072) p = -131072;
    return int'(p);
`else
    if (i < 0) return 0;
    return x;
`endif
  endfunction

  function automatic int get_beat(int k);
    if (k < beat_data.size()) return beat_data[k];
    return -999999;
  endfunction

  function automatic int get_index(int k);
    if (k < beat_index.size()) return beat_index[k];
    return -1;
  endfunction

  task automatic model_edge();
    bit v, was_busy;
    if (reset) begin
      m_n = 0; m_active = 0; m_pos = 0; m_wait = 0; m_ovr = 0;
      return;
    end
    v = m_active && (m_wait == 0);
    was_busy = m_active;
    m_ovr = 0;
    if (v && s_ready) begin
      m_pos++;
      if (m_pos == 16) m_active = 0;
    end else if (m_active && m_wait > 0) begin
      m_wait--;
    end
    if (new_t) begin
      m_n++;
      if (m_n == 16 || (m_n > 16 && (m_n - 16) % HOP == 0)) begin
        if (was_busy) m_ovr = 1;
        else begin
          for (int i = 0; i < 16; i++) m_frame[i] = win(sx(tap[15-i]), i);
          m_active = 1; m_pos = 0; m_wait = LAT - 1;
        end
      end
    end
  endtask

  task automatic cmp_loop();
    bit ev;
    forever begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (!reset && run_cmp) begin
        ev = m_active && (m_wait == 0);
        check("valid", int'(s_valid), int'(ev));
        if (ev) begin
          check("data", sx(s_data), m_frame[m_pos]);
          check("index", int'(s_index), m_pos);
          check("last", int'(s_last), int'(m_pos == 15));
        end else begin
          check("last_idle", int'(s_last), 0);
        end
        check("overrun", int'(overrun), int'(m_ovr));
      end
      if (!reset) begin
        if (s_valid && s_ready) begin
          beat_data.push_back(sx(s_data));
          beat_index.push_back(int'(s_index));
          $display("beat idx=%0d data=%0d last=%0d", s_index, sx(s_data), s_last);
          if (s_last) frames++;
        end
        if (overrun) begin
          ovr_cnt++;
          $display("overrun pulse at %0t", $time);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    new_t = 1'b0;
    case (rmode)
      0:       s_ready = 1'b1;
      1:       s_ready = ($urandom_range(0, 3) != 0);
      default: s_ready = 1'b0;
    endcase
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic pulse();
    new_t = 1'b1;
    tick();
  endtask

  task automatic shift_in(int v);
    for (int i = 15; i > 0; i--) tap[i] = tap[i-1];
    tap[0] = 18'(v);
    pulse();
  endtask

  task automatic set_all(int v);
    for (int i = 0; i < 16; i++) tap[i] = 18'(v);
  endtask

  task automatic wait_frames(int target, int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      tick();
      n++;
    end
    check("frame_timeout", int'(frames >= target), 1);
  endtask

  task automatic check_ramp(int b0);
    check("ramp_count", beat_data.size() - b0, 16);
    for (int i = 0; i < 16; i++) begin
      check("ramp_index", get_index(b0 + i), i);
`ifndef HANN_WINDOW_EN
      check("ramp_data", get_beat(b0 + i), 150 - 10 * i);
`endif
    end
  endtask

  initial begin
    int b0, o0, f0, n;
    fork
      cmp_loop();
    join_none
    set_all(0);

    // Reset
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", int'(s_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_index", int'(s_index), 0);
    check("rst_data", sx(s_data), 0);
    check("rst_last", int'(s_last), 0);
    run_cmp = 1'b1;

    // Warm-up and ordering: t_k = 10k
    rmode = 0;
    for (int k = 0; k < 16; k++) tap[k] = 18'(10 * k);
    for (int s = 0; s < 15; s++) begin
      pulse();
      idle(19);
    end
    check("warm_novalid", int'(s_valid), 0);
    check("warm_noframe", frames, 0);
    b0 = beat_data.size();
    pulse();
    @(negedge clk);
    check("lat_first", int'(s_valid), int'(LAT == 1));
    tick();
    @(negedge clk);
    check("lat_second", int'(s_valid), 1);
    wait_frames(1, 100);
    check_ramp(b0);
    for (int s = 0; s < 8; s++) begin
      pulse();
      idle(23);
    end
    wait_frames(2, 100);
    idle(100);
    check("warm_frames", frames, 2);
    check("warm_no_ovr", ovr_cnt, 0);

    // Overrun: stalled frame survives a dropped trigger
    rmode = 2;
    b0 = beat_data.size();
    o0 = ovr_cnt;
    for (int s = 0; s < 16; s++) begin
      pulse();
      idle(3);
    end
    idle(5);
    check("ovr_count", ovr_cnt - o0, 1);
    check("ovr_stalled", beat_data.size() - b0, 0);
    rmode = 0;
    tick();
    wait_frames(3, 100);
    check_ramp(b0);

    // Window literals
    set_all(1000);
    b0 = beat_data.size();
    for (int s = 0; s < 8; s++) begin
      pulse();
      idle(23);
    end
    wait_frames(4, 100);
`ifdef HANN_WINDOW_EN
    check("win_i0", get_beat(b0 + 0), 0);
    check("win_i4", get_beat(b0 + 4), 500);
    check("win_i8", get_beat(b0 + 8), 1000);
`else
    check("win_i0", get_beat(b0 + 0), 1000);
    check("win_i4", get_beat(b0 + 4), 1000);
    check("win_i8", get_beat(b0 + 8), 1000);
`endif
    set_all(-131072);
    b0 = beat_data.size();
    for (int s = 0; s < 8; s++) begin
      pulse();
      idle(23);
    end
    wait_frames(5, 100);
`ifdef HANN_WINDOW_EN
    check("win_neg_i8", get_beat(b0 + 8), -131071);
`else
    check("win_neg_i8", get_beat(b0 + 8), -131072);
`endif

    // Randomised back-pressure with a shifting sample window
    rmode = 1;
    for (int s = 0; s < 300; s++) begin
      shift_in(int'($urandom_range(0, 262143)));
      idle(int'($urandom_range(0, 30)));
    end
    rmode = 0;
    idle(60);

    // Reset in the middle of a frame
    rmode = 2;
    n = 0;
    while (!s_valid && n < 40) begin
      pulse();
      idle(2);
      n++;
    end
    check("mid_started", int'(s_valid), 1);
    rmode = 0;
    idle(4);
    f0 = frames;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", int'(s_valid), 0);
    check("mid_rst_last", int'(s_last), 0);
    check("mid_rst_index", int'(s_index), 0);
    check("mid_rst_data", sx(s_data), 0);
    check("mid_rst_overrun", int'(overrun), 0);
    idle(30);
    check("mid_no_last", frames, f0);
    for (int s = 0; s < 16; s++) begin
      shift_in(int'($urandom_range(0, 262143)));
      idle(3);
    end
    wait_frames(f0 + 1, 200);
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_streamer.md
# fft_frame_streamer

Downstream neighbour of the I2S microphone sample shifter. It watches the shifter's `new_t` strobe and its 16-tap sample window `t0..t15`, and snapshots a 16-point frame every `HOP` new samples. It then streams that frame oldest-first, one sample per handshake, into the FFT processor's input port. An optional Hann window is applied on the way out.

## Interface
- `HOP`, default 8: new samples between successive frames; legal range 1..16.
- `clk`  in  1: system clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `new_t`  in  1: one-cycle strobe. When high, `t0..t15` already hold the updated window in that same cycle.
- `t0..t15`  in  18 each: 18-bit two's-complement samples; `t0` is newest, `t15` is oldest.
- `s_data`  out  18: frame sample, two's complement.
- `s_index`  out  4: position of `s_data` within the frame; 0 is the oldest sample.
- `s_valid`  out  1: `s_data`, `s_index` and `s_last` are valid.
- `s_ready`  in  1: the FFT input accepts the sample.
- `s_last`  out  1: high with `s_index` = 15.
- `overrun`  out  1: one-cycle pulse when a frame trigger is dropped.

## Operation
- **Fill counter**
  - Saturating 5-bit counter of `new_t` strobes since reset, saturating at 16.
  - No frame is triggered until the count reaches 16.
- **Hop counter**
  - Counts 0..HOP-1 on each `new_t`; wraps to 0 when it generates a trigger.
  - Trigger = `new_t` high AND (the fill count becomes 16 on this strobe, OR fill = 16 and hop = HOP-1).
  - The hop counter clears when the fill count first reaches 16.
- **FSM states: IDLE, STREAM.**
  - IDLE + trigger: latch `t15..t0` into frame registers `f[0..15]` (`f[0]` = `t15`), set index = 0, go to STREAM.
  - STREAM: `s_valid` = 1. On `s_valid && s_ready`, index increments.
  - On the handshake at index 15, go to IDLE.
  - While `s_valid && !s_ready`, `s_data`, `s_index` and `s_last` must hold stable.
- **Trigger during STREAM**
  - The frame is dropped and `overrun` pulses for one cycle.
  - The frame registers and stream are unaffected.
  - The hop counter still wraps as normal.
- **Trigger in the same cycle as the final handshake** (index 15 accepted): the trigger is dropped and `overrun` pulses. The FSM returns to IDLE.
- **Output data**: `s_data` = `f[index]`, passed through the window when enabled.
- **Reset** at any time, including mid-stream:
  - FSM goes to IDLE, counters clear, frame registers clear.
  - The partial frame is abandoned; no `s_last` is emitted.

## Timing
- **Reset values**: `s_valid` = 0, `s_last` = 0, `s_index` = 0, `s_data` = 0, `overrun` = 0.
- **Latency**: `s_valid` rises on the first cycle after the capturing edge, i.e. one clock after `new_t`.
- **Minimum frame duration**: 16 cycles with `s_ready` held high; samples go out back-to-back with no bubbles.
- **Output timing**: outputs are registered or derived from registers only. There is no combinational path from `s_ready` to `s_valid`.
- **`overrun` timing**: asserted in the cycle after the dropped trigger, for exactly one cycle.
- **Nominal input rate**: one `new_t` per 64 clocks, so overrun occurs only under sustained back-pressure.

## Configuration
- **`HANN_WINDOW_EN` defined**: `s_data` = sat18(round((`f[i]` × `w[i]`) >>> 17)).
  - `w[i]` is 17-bit unsigned Q0.17 periodic Hann: 0.5·(1 − cos(2πi/16))·2^17, saturated to 131071.
  - Product is 36-bit signed. Add 2^16 before the arithmetic shift, then saturate to the 18-bit signed range.
  - The multiply result is registered. `s_valid` rises two clocks after `new_t`, and the one-deep skid must preserve the hold-under-back-pressure rule.
- **`HANN_WINDOW_EN` undefined**: `s_data` = `f[i]` unmodified, latency one clock, no multiplier instantiated.

## Structure
- **Package `audio_pkg`**:
  - `NPTS` = 16, `SAMPLE_W` = 18, `COEF_W` = 17.
  - `hann_coef[0:15]` constant array.
  - FSM state enum `{IDLE, STREAM}`.
- **Sub-module `hann_window_mult`**: multiply, round and saturate stage, instantiated only under `HANN_WINDOW_EN`.

## Test plan
1. **Reset**: assert `reset` for 2 cycles, then release. Expect `s_valid` = 0, `overrun` = 0, `s_index` = 0, `s_data` = 0, `s_last` = 0.
2. **Warm-up**: HOP = 8, 15 `new_t` strobes, then no `s_valid`. The 16th strobe gives `s_valid` one clock later. Eight further strobes give exactly one more frame.
3. **Ordering** (window off): `t_k` = 10·k with `s_ready` = 1. Expect 16 consecutive beats, `s_data` = 150, 140, …, 0, `s_index` 0..15, `s_last` only on the beat with value 0.
4. **Back-pressure**: toggle `s_ready` pseudo-randomly. `s_data` and `s_index` must hold while `!s_ready`; all 16 values are delivered once and in order.
5. **Overrun**: hold `s_ready` = 0 through 8 more `new_t` strobes. Expect a single 1-cycle `overrun` and an unchanged in-flight frame, which completes intact after `s_ready` = 1.
6. **Window on**: all taps = 1000. Expect index 0 → 0, index 4 → 500, index 8 → 1000. With all taps = −131072, index 8 → −131071 and no wrap.
